fp_fma_seq: RTL and testbench

- Parametrised floating-point sequencer that computes a*b, a+c, a*b+c or a*b-c on externally instantiated multiplier and adder cores.
- The cores are fp_mul and add, both with clk_en gating.
- Adds to the earlier fixed multiply-then-add controller:
  - a runtime operation mode;
  - configurable latencies and data width;
  - a start/busy/done handshake with operand capture.
- Sits between the CORDIC iteration control and the shared FP units.

---
 rtl/fp_fma_seq.sv | 154 +++++++++++++++
 tb/tb_fp_fma_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_fma_seq.sv
// Floating-point operation sequencer that drives external multiplier and adder cores.
// It computes a*b, a+c, a*b+c or a*b-c. Operands are captured when start is accepted,
// and each core's clk_en is held high for exactly its pipeline latency.
module fp_fma_seq #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MUL_LATENCY   = 5,
  parameter int unsigned ADD_LATENCY   = 7,
  parameter int unsigned COUNTER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] dataa,
  input  logic [DATA_WIDTH-1:0] datab,
  input  logic [DATA_WIDTH-1:0] datac,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  mul_en,
  output logic [DATA_WIDTH-1:0] mul_a,
  output logic [DATA_WIDTH-1:0] mul_b,
  input  logic [DATA_WIDTH-1:0] mul_result,
  output logic                  add_en,
  output logic [DATA_WIDTH-1:0] add_a,
  output logic [DATA_WIDTH-1:0] add_b,
  input  logic [DATA_WIDTH-1:0] add_result
);

  localparam logic [1:0] ModeMul = 2'b00;
  localparam logic [1:0] ModeAdd = 2'b01;
  localparam logic [1:0] ModeFma = 2'b10;
  localparam logic [1:0] ModeFms = 2'b11;

  // The counter is loaded with latency-1, so the run ends on the cycle it reads zero.
  localparam logic [COUNTER_WIDTH-1:0] MulLoad = COUNTER_WIDTH'(MUL_LATENCY - 1);
  localparam logic [COUNTER_WIDTH-1:0] AddLoad = COUNTER_WIDTH'(ADD_LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StMulRun,
    StAddRun,
    StDone
  } state_e;

  state_e                  state_q;
  logic [1:0]              mode_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [DATA_WIDTH-1:0]   c_q;
  logic [DATA_WIDTH-1:0]   prod_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    mul_en_q;
  logic                    add_en_q;

  // Sequencer FSM: every control output is registered here alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mode_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      prod_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mul_en_q <= 1'b0;
      add_en_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q    <= dataa;
            b_q    <= datab;
            c_q    <= datac;
            mode_q <= mode;
            busy_q <= 1'b1;
            if (mode == ModeAdd) begin
              state_q  <= StAddRun;
              add_en_q <= 1'b1;
              cnt_q    <= AddLoad;
            end else begin
              state_q  <= StMulRun;
              mul_en_q <= 1'b1;
              cnt_q    <= MulLoad;
            end
          end
        end
        StMulRun: begin
          if (cnt_q == '0) begin
            prod_q   <= mul_result;
            mul_en_q <= 1'b0;
            if (mode_q == ModeMul) begin
              result_q <= mul_result;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              add_en_q <= 1'b1;
              cnt_q    <= AddLoad;
              state_q  <= StAddRun;
            end
          end else begin
            cnt_q <= cnt_q - COUNTER_WIDTH'(1);
          end
        end
        StAddRun: begin
          if (cnt_q == '0) begin
            result_q <= add_result;
            add_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q - COUNTER_WIDTH'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Core operands come straight from the capture registers, so they stay stable across a run.
  always_comb begin
    mul_a = a_q;
    mul_b = b_q;
    add_a = (mode_q == ModeAdd) ? a_q : prod_q;
    add_b = c_q;
    // FMS subtracts c by flipping its sign bit; no other FP arithmetic is done here.
    add_b[DATA_WIDTH-1] = c_q[DATA_WIDTH-1] ^ (mode_q == ModeFms);
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign mul_en = mul_en_q;
  assign add_en = add_en_q;

  // ModeFma is listed for completeness; it shares the default multiply-then-add path.
  logic unused_mode_fma;
  assign unused_mode_fma = ^ModeFma;

endmodule

// File: tb/tb_fp_fma_seq.sv
// Bench for fp_fma_seq. It uses lookup-table unit models with latency-gated outputs,
// a cycle-indexed reference model, and a result scoreboard fed at every start.
module tb_fp_fma_seq;

  localparam int DW = 32;
  localparam int ML = 5;
  localparam int AL = 7;

  localparam logic [1:0] OpMul = 2'b00;
  localparam logic [1:0] OpAdd = 2'b01;
  localparam logic [1:0] OpFma = 2'b10;
  localparam logic [1:0] OpFms = 2'b11;

  localparam logic [31:0] F1    = 32'h3F80_0000;
  localparam logic [31:0] F2    = 32'h4000_0000;
  localparam logic [31:0] F3    = 32'h4040_0000;
  localparam logic [31:0] F5    = 32'h40A0_0000;
  localparam logic [31:0] F6    = 32'h40C0_0000;
  localparam logic [31:0] F7    = 32'h40E0_0000;
  localparam logic [31:0] FNeg1 = 32'hBF80_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] dataa = '0;
  logic [DW-1:0] datab = '0;
  logic [DW-1:0] datac = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          mul_en;
  logic [DW-1:0] mul_a;
  logic [DW-1:0] mul_b;
  logic [DW-1:0] mul_result;
  logic          add_en;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic [DW-1:0] add_result;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  fp_fma_seq #(
    .DATA_WIDTH   (DW),
    .MUL_LATENCY  (ML),
    .ADD_LATENCY  (AL),
    .COUNTER_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .dataa     (dataa),
    .datab     (datab),
    .datac     (datac),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .mul_en    (mul_en),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_result(mul_result),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_result(add_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mul_lut(input logic [31:0] a, input logic [31:0] b);
    if (a == F2 && b == F3) return F6;
    if (a == F1 && b == F2) return F2;
    return 32'hBAD0_0001;
  endfunction

  function automatic logic [31:0] add_lut(input logic [31:0] a, input logic [31:0] b);
    if (a == F6 && b == F1) return F7;
    if (a == F6 && b == FNeg1) return F5;
    if (a == F2 && b == F1) return F3;
    return 32'hBAD0_0002;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Unit models: the output is valid only on the last enabled cycle of a full-latency run.
  int mul_cnt = 0;
  int add_cnt = 0;
  always @(posedge clk) begin
    mul_cnt <= mul_en ? mul_cnt + 1 : 0;
    add_cnt <= add_en ? add_cnt + 1 : 0;
  end
  assign mul_result = (mul_en && mul_cnt == ML - 1) ? mul_lut(mul_a, mul_b) : 32'hDEAD_BEEF;
  assign add_result = (add_en && add_cnt == AL - 1) ? add_lut(add_a, add_b) : 32'hDEAD_BEEF;

  // Reference model: m_k counts cycles since the accepting edge; done falls on cycle m_dlat.
  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_dlat = 0;
  logic [1:0]  m_mode = 2'b00;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] m_c = '0;
  logic [31:0] hold_res = '0;
  int          cyc = 0;
  int          last_done_cyc = -1;
  int          prev_done_cyc = -1;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      hold_res = '0;
    end else if (m_active) begin
      m_k++;
      if (m_k > m_dlat) m_active = 1'b0;
    end else if (start) begin
      m_active = 1'b1;
      m_k      = 0;
      m_mode   = mode;
      m_a      = dataa;
      m_b      = datab;
      m_c      = datac;
      m_dlat   = (mode == OpMul) ? ML : (mode == OpAdd) ? AL : ML + AL;
    end
  end

  bit          e_done, e_busy, e_mul, e_add;
  logic [31:0] e_res;

  always @(negedge clk) begin
    cyc++;
    e_done = m_active && m_k == m_dlat;
    e_busy = m_active && m_k < m_dlat;
    e_mul  = m_active && m_mode != OpAdd && m_k < ML;
    e_add  = m_active && ((m_mode == OpAdd) ? m_k < AL :
                          (m_mode != OpMul && m_k >= ML && m_k < ML + AL));
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("mul_en", mul_en, e_mul);
    chk("add_en", add_en, e_add);
    if (e_mul) begin
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
    end
    if (e_add) begin
      chk("add_a", add_a, (m_mode == OpAdd) ? m_a : mul_lut(m_a, m_b));
      chk("add_b", add_b, (m_mode == OpFms) ? (m_c ^ 32'h8000_0000) : m_c);
    end
    if (e_done) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_empty observed done with %0d entries expected >0", sb_q.size());
      end
      if (sb_q.size() != 0) begin
        e_res = sb_q.pop_front();
        chk("result", result, e_res);
        hold_res = e_res;
      end
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end else begin
      chk("result_hold", result, hold_res);
    end
  end

  // Present one operation on the next negedge; drop start and scramble inputs after acceptance.
  task automatic go(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] c, input logic [31:0] exp);
    @(negedge clk);
    start = 1'b1;
    mode  = md;
    dataa = a;
    datab = b;
    datac = c;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = ~md;
    dataa = 32'h1234_5678;
    datab = 32'h9ABC_DEF0;
    datac = 32'h0F0F_0F0F;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < max);
    checks++;
    assert (done === 1'b1) else begin
      errors++;
      $error("FAIL done_timeout observed no done after %0d cycles expected within %0d", n, max);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish before timeout");
    $fatal(1);
  end

  int n;

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mul_en", mul_en, 1'b0);
    chk("rst_add_en", add_en, 1'b0);
    chk("rst_result", result, 32'h0);

    go(OpFma, F2, F3, F1, F7);
    wait_done(40, n);
    chk("fma_lat", n, 13);

    go(OpFms, F2, F3, F1, F5);
    wait_done(40, n);
    chk("fms_lat", n, 13);

    go(OpMul, F2, F3, F1, F6);
    wait_done(40, n);
    chk("mul_lat", n, 6);

    go(OpAdd, F2, 32'h5555_5555, F1, F3);
    wait_done(40, n);
    chk("add_lat", n, 8);

    // start held high across two operations, with inputs scrambled while busy
    @(negedge clk);
    start = 1'b1;
    mode  = OpFma;
    dataa = F2;
    datab = F3;
    datac = F1;
    sb_q.push_back(F7);
    @(posedge clk);
    #1;
    mode  = OpAdd;
    dataa = 32'h7777_0000;
    datab = 32'h0000_7777;
    datac = 32'h7070_7070;
    wait_done(40, n);
    chk("hold1_lat", n, 13);
    mode  = OpFma;
    dataa = F1;
    datab = F2;
    datac = F1;
    sb_q.push_back(F3);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    dataa = 32'hFFFF_0000;
    datab = 32'h0000_FFFF;
    datac = 32'hF0F0_F0F0;
    wait_done(40, n);
    chk("hold2_lat", n, 13);
    chk("done_spacing", last_done_cyc - prev_done_cyc, 14);

    // reset during the adder run aborts with no done
    go(OpAdd, F2, F3, F1, F3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_add_en", add_en, 1'b0);
    chk("abort_mul_en", mul_en, 1'b0);
    chk("abort_result", result, 32'h0);
    chk("abort_add_a", add_a, 32'h0);
    repeat (12) @(negedge clk);

    go(OpFma, F2, F3, F1, F7);
    wait_done(40, n);
    chk("post_rst_lat", n, 13);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
